controller: RTL and testbench



---
 rtl/controller_if.sv | 49 ++++
 rtl/controller.sv | 115 +++++++++++
 tb/tb_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/controller_if.sv
// Shared opcode/control encodings and the controller <-> datapath bundle.
// The package sits here because the interface ports are typed with it.
package opcodes;

  typedef enum logic [2:0] {
    AluPassA, AluPassB, AluAdd, AluSub, AluAnd, AluOr, AluXor
  } alu_functions_t;

  typedef enum logic {
    PcInc, PcJmp
  } PcSel_t;

  typedef enum logic [3:0] {
    OpNop  = 4'h0, OpLdi = 4'h1, OpLdih = 4'h2, OpAddi = 4'h3,
    OpAdd  = 4'h4, OpSub = 4'h5, OpAnd  = 4'h6, OpOr   = 4'h7,
    OpXor  = 4'h8, OpLd  = 4'h9, OpSt   = 4'hA, OpIn   = 4'hB,
    OpJmp  = 4'hC, OpJz  = 4'hD, OpJnz  = 4'hE, OpHalt = 4'hF
  } opcode_t;

endpackage

interface controller_if #(
  parameter int n = 8
);
  logic [n-1:0]             MemData;
  logic [n-1:0]             Acc;
  logic                     Run;
  logic                     SwValid;
  logic                     SwAck;
  logic                     RegWe;
  logic                     ImmSel;
  logic                     WDataSel;
  logic                     AccWe;
  logic                     Op1Sel;
  logic                     PcWe;
  opcodes::alu_functions_t  AluOp;
  opcodes::PcSel_t          PcSel;
  logic                     Halted;

  modport slave (
    input  MemData, Acc, Run, SwValid,
    output SwAck, RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe, AluOp, PcSel, Halted
  );

  modport master (
    output MemData, Acc, Run, SwValid,
    input  SwAck, RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe, AluOp, PcSel, Halted
  );
endinterface

// File: rtl/controller.sv
// Multi-cycle accumulator CPU controller: FETCH/EXEC sequencing, switch-input
// handshake and halt. Datapath controls are decoded from the opcode nibble.
module controller #(
  parameter int n = 8
) (
  input logic       Clock,
  input logic       nReset,
  controller_if.slave bus
);
  import opcodes::*;

  typedef enum logic [1:0] {StFetch, StExec, StSwWait, StHalt} state_e;

  state_e         state_q, state_d;
  opcode_t        opcode;
  logic [n-1:0]   acc_w;
  logic           acc_zero;
  logic           unused_operand;

  logic           reg_we, imm_sel, wdata_sel, acc_we, op1_sel, pc_we, sw_ack, halted;
  alu_functions_t alu_op;
  PcSel_t         pc_sel;

  assign opcode         = opcode_t'(bus.MemData[7:4]);
  assign acc_w          = bus.Acc;
  assign acc_zero       = (acc_w == '0);
  // Operand bits are routed to the register file by the datapath, not used here.
  assign unused_operand = ^bus.MemData;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= StFetch;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (bus.Run) state_d = StExec;
      StExec: begin
        unique case (opcode)
          OpIn:    state_d = bus.SwValid ? StFetch : StSwWait;
          OpHalt:  state_d = StHalt;
          default: state_d = StFetch;
        endcase
      end
      StSwWait: if (bus.SwValid) state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    reg_we    = 1'b0;
    imm_sel   = 1'b0;
    wdata_sel = 1'b0;
    acc_we    = 1'b0;
    op1_sel   = 1'b0;
    pc_we     = 1'b0;
    sw_ack    = 1'b0;
    halted    = 1'b0;
    alu_op    = AluPassA;
    pc_sel    = PcInc;
    unique case (state_q)
      StExec: begin
        unique case (opcode)
          OpNop:  pc_we = 1'b1;
          OpLdi:  begin op1_sel = 1'b1; acc_we = 1'b1; pc_we = 1'b1; end
          OpLdih: begin op1_sel = 1'b1; imm_sel = 1'b1; acc_we = 1'b1; pc_we = 1'b1; end
          OpAddi: begin op1_sel = 1'b1; alu_op = AluAdd; acc_we = 1'b1; pc_we = 1'b1; end
          OpAdd:  begin alu_op = AluAdd; acc_we = 1'b1; pc_we = 1'b1; end
          OpSub:  begin alu_op = AluSub; acc_we = 1'b1; pc_we = 1'b1; end
          OpAnd:  begin alu_op = AluAnd; acc_we = 1'b1; pc_we = 1'b1; end
          OpOr:   begin alu_op = AluOr;  acc_we = 1'b1; pc_we = 1'b1; end
          OpXor:  begin alu_op = AluXor; acc_we = 1'b1; pc_we = 1'b1; end
          OpLd:   begin acc_we = 1'b1; pc_we = 1'b1; end
          OpSt:   begin reg_we = 1'b1; pc_we = 1'b1; end
          OpIn: begin
            // Without switch data nothing is asserted; SWWAIT performs the write.
            if (bus.SwValid) begin
              reg_we = 1'b1; wdata_sel = 1'b1; sw_ack = 1'b1; pc_we = 1'b1;
            end
          end
          OpJmp:  begin alu_op = AluPassB; pc_sel = PcJmp; pc_we = 1'b1; end
          OpJz:   begin alu_op = AluPassB; pc_we = 1'b1; if (acc_zero)  pc_sel = PcJmp; end
          OpJnz:  begin alu_op = AluPassB; pc_we = 1'b1; if (!acc_zero) pc_sel = PcJmp; end
          OpHalt: ;
          default: ;
        endcase
      end
      StSwWait: begin
        wdata_sel = 1'b1;
        if (bus.SwValid) begin
          reg_we = 1'b1; sw_ack = 1'b1; pc_we = 1'b1;
        end
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.RegWe    = reg_we;
  assign bus.ImmSel   = imm_sel;
  assign bus.WDataSel = wdata_sel;
  assign bus.AccWe    = acc_we;
  assign bus.Op1Sel   = op1_sel;
  assign bus.PcWe     = pc_we;
  assign bus.SwAck    = sw_ack;
  assign bus.Halted   = halted;
  assign bus.AluOp    = alu_op;
  assign bus.PcSel    = pc_sel;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: each cycle's expected control word is queued
// when inputs are driven and compared when the outputs are sampled.
module tb_controller;
  import opcodes::*;

  typedef struct packed {
    logic           halted;
    logic           swack;
    logic           regwe;
    logic           immsel;
    logic           wdatasel;
    logic           accwe;
    logic           op1sel;
    logic           pcwe;
    PcSel_t         pcsel;
    alu_functions_t aluop;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  exp;
  } sb_item_t;

  logic Clock = 1'b0;
  logic nReset;
  int   n_checks = 0;
  int   n_errors = 0;
  sb_item_t sb[$];

  controller_if #(.n(8)) bus ();
  controller #(.n(8)) dut (.Clock(Clock), .nReset(nReset), .bus(bus.slave));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic ctl_t zero_ctl();
    ctl_t c;
    c = '0;
    c.aluop = AluPassA;
    c.pcsel = PcInc;
    return c;
  endfunction

  // Expected EXEC-cycle controls, written out opcode by opcode from the decode table.
  function automatic ctl_t exec_exp(input logic [3:0] op, input logic acc_zero, input logic swv);
    ctl_t e;
    e = zero_ctl();
    case (op)
      4'h0: e.pcwe = 1'b1;
      4'h1: begin e.op1sel = 1'b1; e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h2: begin e.op1sel = 1'b1; e.immsel = 1'b1; e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h3: begin e.op1sel = 1'b1; e.aluop = AluAdd; e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h4: begin e.aluop = AluAdd; e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h5: begin e.aluop = AluSub; e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h6: begin e.aluop = AluAnd; e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h7: begin e.aluop = AluOr;  e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h8: begin e.aluop = AluXor; e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'h9: begin e.accwe = 1'b1; e.pcwe = 1'b1; end
      4'hA: begin e.regwe = 1'b1; e.pcwe = 1'b1; end
      4'hB: if (swv) begin e.regwe = 1'b1; e.wdatasel = 1'b1; e.swack = 1'b1; e.pcwe = 1'b1; end
      4'hC: begin e.aluop = AluPassB; e.pcsel = PcJmp; e.pcwe = 1'b1; end
      4'hD: begin e.aluop = AluPassB; e.pcwe = 1'b1; e.pcsel = acc_zero ? PcJmp : PcInc; end
      4'hE: begin e.aluop = AluPassB; e.pcwe = 1'b1; e.pcsel = acc_zero ? PcInc : PcJmp; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t s;
    s.halted   = bus.Halted;
    s.swack    = bus.SwAck;
    s.regwe    = bus.RegWe;
    s.immsel   = bus.ImmSel;
    s.wdatasel = bus.WDataSel;
    s.accwe    = bus.AccWe;
    s.op1sel   = bus.Op1Sel;
    s.pcwe     = bus.PcWe;
    s.pcsel    = bus.PcSel;
    s.aluop    = bus.AluOp;
    return s;
  endfunction

  // One clock cycle: drive just after the rising edge, compare on the falling edge.
  task automatic cyc(input string tag, input logic [7:0] mem, input logic [7:0] acc,
                     input logic run, input logic swv, input logic rst, input ctl_t e);
    sb_item_t it;
    @(posedge Clock);
    #1;
    bus.MemData = mem;
    bus.Acc     = acc;
    bus.Run     = run;
    bus.SwValid = swv;
    nReset      = rst;
    sb.push_back('{tag, e});
    @(negedge Clock);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      it = sb.pop_front();
      check(it.tag, 32'(sample()), 32'(it.exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_t z, w, wr, h;
    logic [7:0] acc, mem;
    z  = zero_ctl();
    w  = z; w.wdatasel = 1'b1;
    wr = w; wr.regwe = 1'b1; wr.swack = 1'b1; wr.pcwe = 1'b1;
    h  = z; h.halted = 1'b1;

    nReset = 1'b0;
    bus.MemData = 8'h15; bus.Acc = 8'h00; bus.Run = 1'b1; bus.SwValid = 1'b0;
    #2;
    check("in_reset", 32'(sample()), 32'(z));

    cyc("rst",       8'h15, 8'h00, 1'b1, 1'b0, 1'b0, z);
    cyc("ldi_fetch", 8'h15, 8'h00, 1'b1, 1'b0, 1'b1, z);
    cyc("ldi_exec",  8'h15, 8'h00, 1'b1, 1'b0, 1'b1, exec_exp(4'h1, 1'b1, 1'b0));

    for (int a = 0; a < 2; a++) begin
      for (int op = 0; op < 15; op++) begin
        acc = (a == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        mem = {4'(op), 4'($urandom_range(0, 15))};
        cyc($sformatf("fetch_op%0h_a%0d", op, a), mem, acc, 1'b1, 1'b1, 1'b1, z);
        cyc($sformatf("exec_op%0h_a%0d", op, a), mem, acc, 1'b1, 1'b1, 1'b1,
            exec_exp(4'(op), acc == 8'h00, 1'b1));
      end
    end

    cyc("in_fetch", 8'hB3, 8'h00, 1'b1, 1'b0, 1'b1, z);
    cyc("in_exec",  8'hB3, 8'h00, 1'b1, 1'b0, 1'b1, z);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("in_wait%0d", i), 8'hB3, 8'h00, 1'b0, 1'b0, 1'b1, w);
    cyc("in_write", 8'hB3, 8'h00, 1'b0, 1'b1, 1'b1, wr);
    cyc("in_back",  8'hB3, 8'h00, 1'b0, 1'b0, 1'b1, z);

    for (int i = 0; i < 5; i++)
      cyc($sformatf("pause%0d", i), 8'h15, 8'h00, 1'b0, 1'b0, 1'b1, z);
    cyc("resume_fetch", 8'h15, 8'h00, 1'b1, 1'b0, 1'b1, z);
    cyc("resume_exec",  8'h15, 8'h00, 1'b1, 1'b0, 1'b1, exec_exp(4'h1, 1'b1, 1'b0));

    cyc("halt_fetch", 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1, z);
    cyc("halt_exec",  8'hF0, 8'h00, 1'b1, 1'b0, 1'b1, z);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("halted%0d", i), 8'($urandom_range(0, 255)), 8'h00, 1'b1, 1'b1, 1'b1, h);
    cyc("halt_rst",   8'h00, 8'h00, 1'b1, 1'b0, 1'b0, z);
    cyc("halt_fetch2", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, z);
    cyc("halt_nop",   8'h00, 8'h00, 1'b1, 1'b0, 1'b1, exec_exp(4'h0, 1'b1, 1'b0));

    cyc("abort_fetch", 8'hB7, 8'h00, 1'b1, 1'b0, 1'b1, z);
    cyc("abort_exec",  8'hB7, 8'h00, 1'b1, 1'b0, 1'b1, z);
    cyc("abort_wait",  8'hB7, 8'h00, 1'b1, 1'b0, 1'b1, w);
    cyc("abort_rst",   8'hB7, 8'h00, 1'b1, 1'b1, 1'b0, z);
    cyc("abort_rel",   8'hB7, 8'h00, 1'b0, 1'b1, 1'b1, z);
    cyc("abort_idle",  8'hB7, 8'h00, 1'b0, 1'b1, 1'b1, z);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
